// File: rtl/i2s_tx.sv
// i2s_tx: Philips-format I2S serialiser for 16-bit stereo pairs with a one-deep holding register.
module i2s_tx #(
    parameter int BCLK_HALF    = 16,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    input  logic                    sample_valid_in,
    output logic                    sample_ready_out,
    output logic                    bclk_out,
    output logic                    lrclk_out,
    output logic                    sdata_out,
    output logic                    frame_start_out,
    output logic                    underrun_out
);
    localparam int DW = $clog2(BCLK_HALF);
    localparam int IW = $clog2(2 * SLOT_WIDTH);
    localparam int FW = 2 * SAMPLE_WIDTH;

    logic [DW-1:0] div_q, div_d;
    logic [IW-1:0] bit_q, bit_d;
    logic [FW-1:0] hold_q, hold_d, frame_q, frame_d;
    logic          bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic          frame_start_q, frame_start_d, underrun_q, underrun_d;
    logic          hold_full_q, hold_full_d;
    logic          tc, fall, load, accept, slot_r;
    int            pos;
    logic [SAMPLE_WIDTH-1:0] word, shifted;

    always_comb begin
        tc            = div_q == DW'(BCLK_HALF - 1);
        fall          = tc && bclk_q;
        load          = fall && (bit_q == IW'(2 * SLOT_WIDTH - 1));
        accept        = sample_valid_in && !hold_full_q;
        div_d         = tc ? '0 : div_q + 1'b1;
        bclk_d        = bclk_q ^ tc;
        bit_d         = load ? '0 : bit_q + IW'(fall);
        hold_full_d   = accept || (hold_full_q && !load);
        hold_d        = accept ? {left_in, right_in} : hold_q;
        frame_d       = load ? (hold_full_q ? hold_q : '0) : frame_q;
        // Output bit is chosen from the post-advance index so it lands on the falling edge.
        slot_r        = bit_d >= IW'(SLOT_WIDTH);
        pos           = slot_r ? int'(bit_d) - SLOT_WIDTH : int'(bit_d);
        word          = slot_r ? frame_q[SAMPLE_WIDTH-1:0] : frame_q[FW-1:SAMPLE_WIDTH];
        shifted       = word << (pos - 1);
        lrclk_d       = fall ? slot_r : lrclk_q;
        sdata_d       = fall ? (pos >= 1 && pos <= SAMPLE_WIDTH && shifted[SAMPLE_WIDTH-1]) : sdata_q;
        frame_start_d = load;
        underrun_d    = load && !hold_full_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_q         <= '0;
            bit_q         <= '0;
            hold_q        <= '0;
            frame_q       <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            hold_full_q   <= 1'b0;
        end else begin
            div_q         <= div_d;
            bit_q         <= bit_d;
            hold_q        <= hold_d;
            frame_q       <= frame_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_full_q   <= hold_full_d;
        end
    end

    assign sample_ready_out = !hold_full_q;
    assign bclk_out         = bclk_q;
    assign lrclk_out        = lrclk_q;
    assign sdata_out        = sdata_q;
    assign frame_start_out  = frame_start_q;
    assign underrun_out     = underrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: cycle-level check of i2s_tx against an arithmetic timing/frame model.
module tb_i2s_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] l = '0, r = '0;
    logic [15:0] zero16 = '0;
    logic        ready, bclk, lrclk, sdata, fs, ur;
    logic        d_ready, d_bclk, d_lrclk, d_sdata, d_fs, d_ur;

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0;
    logic        m_full = 1'b0, m_ld = 1'b0, m_und = 1'b0, acc_q = 1'b0;
    logic [31:0] m_hold = '0, m_frame = '0;
    logic [31:0] base;

    i2s_tx #(.BCLK_HALF(2)) dut (
        .clk_in(clk), .rst_in(rst), .left_in(l), .right_in(r),
        .sample_valid_in(valid), .sample_ready_out(ready), .bclk_out(bclk),
        .lrclk_out(lrclk), .sdata_out(sdata), .frame_start_out(fs), .underrun_out(ur)
    );

    i2s_tx u_def (
        .clk_in(clk), .rst_in(rst), .left_in(zero16), .right_in(zero16),
        .sample_valid_in(1'b0), .sample_ready_out(d_ready), .bclk_out(d_bclk),
        .lrclk_out(d_lrclk), .sdata_out(d_sdata), .frame_start_out(d_fs), .underrun_out(d_ur)
    );

    always #5 clk = ~clk;

    // Slot bit k: 1..16 carry left MSB-first, 33..48 carry right MSB-first, all others 0.
    function automatic logic bitof(input logic [31:0] fr, input int k);
        logic [31:0] b;
        b = '0;
        if (k >= 1 && k <= 16) b = fr >> (32 - k);
        else if (k >= 33 && k <= 48) b = fr >> (48 - k);
        return b[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        int idx, didx;
        @(posedge clk);
        acc_q = 1'b0;
        if (rst) begin
            cyc = 0; m_full = 1'b0; m_hold = '0; m_frame = '0; m_ld = 1'b0; m_und = 1'b0;
        end else begin
            cyc++;
            acc_q = valid && !m_full;
            m_ld  = (cyc % 256) == 0;
            m_und = m_ld && !m_full;
            if (m_ld) begin
                m_frame = m_full ? m_hold : '0;
                m_full  = 1'b0;
            end
            if (acc_q) begin
                m_hold = {l, r};
                m_full = 1'b1;
            end
        end
        #1;
        idx  = (cyc / 4) % 64;
        didx = (cyc / 32) % 64;
        chk("bclk", 32'(bclk), 32'((cyc / 2) % 2));
        chk("lrclk", 32'(lrclk), 32'(idx >= 32));
        chk("sdata", 32'(sdata), 32'(bitof(m_frame, idx)));
        chk("ready", 32'(ready), 32'(!m_full));
        chk("frame_start", 32'(fs), 32'(m_ld));
        chk("underrun", 32'(ur), 32'(m_und));
        chk("def_bclk", 32'(d_bclk), 32'((cyc / 16) % 2));
        chk("def_lrclk", 32'(d_lrclk), 32'(didx >= 32));
        chk("def_sdata", 32'(d_sdata), 32'd0);
        chk("def_ready", 32'(d_ready), 32'd1);
        chk("def_frame_start", 32'(d_fs), 32'(cyc > 0 && cyc % 2048 == 0));
        chk("def_underrun", 32'(d_ur), 32'(cyc > 0 && cyc % 2048 == 0));
    endtask

    initial begin
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        for (int i = 0; i < 512; i++) step();
        l = 16'hA5C3; r = 16'h8001; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int i = 0; i < 511; i++) step();
        base = $urandom;
        l = base[15:0]; r = base[31:16]; valid = 1'b1;
        for (int i = 0; i < 1536; i++) begin
            step();
            if (acc_q) begin
                base = base + 32'h0001_0001;
                l = base[15:0]; r = base[31:16];
            end
        end
        valid = 1'b0;
        for (int i = 0; i < 512; i++) step();
        while ((cyc + 1) % 256 != 0) step();
        base = $urandom;
        l = base[15:0]; r = base[31:16]; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int i = 0; i < 512; i++) step();
        base = $urandom;
        l = base[15:0]; r = base[31:16]; valid = 1'b1;
        step();
        valid = 1'b0;
        while ((cyc / 4) % 64 < 40) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) step();
        for (int i = 0; i < 1024; i++) begin
            base = $urandom;
            valid = base[0] & base[1] & base[2];
            l = base[31:16]; r = base[15:0] ^ 16'h5A5A;
            step();
        end
        valid = 1'b0;
        for (int i = 0; i < 512; i++) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
